// File: rtl/sift_pkg.sv
// Shared types and constants for the SIFT gradient pipeline: FSM states,
// read-order tags and the pixel BRAM read latency.
package sift_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } grad_state_t;

    // Order in which the four neighbour reads of one pixel are issued.
    typedef enum logic [1:0] {
        TAG_L = 2'd0,
        TAG_R = 2'd1,
        TAG_U = 2'd2,
        TAG_D = 2'd3
    } read_tag_t;

    localparam int BRAM_RD_LAT = 2;

    function automatic int addr_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/neighbor_addr.sv
// Clamped left/right/up/down neighbour addresses for pixel (x, y); a border
// pixel substitutes its own coordinate for the missing neighbour.
module neighbor_addr
    import sift_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int HEIGHT = 3,
    parameter int ADDR_W = addr_width(WIDTH * HEIGHT)
) (
    input  logic [ADDR_W-1:0] x,
    input  logic [ADDR_W-1:0] y,
    output logic [ADDR_W-1:0] left_addr,
    output logic [ADDR_W-1:0] right_addr,
    output logic [ADDR_W-1:0] up_addr,
    output logic [ADDR_W-1:0] down_addr
);

    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_W   = ADDR_W'(WIDTH);
    localparam logic [ADDR_W-1:0] X_MAX = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] Y_MAX = ADDR_W'(HEIGHT - 1);

    logic [ADDR_W-1:0] xl_s;
    logic [ADDR_W-1:0] xr_s;
    logic [ADDR_W-1:0] yu_s;
    logic [ADDR_W-1:0] yd_s;
    logic [ADDR_W-1:0] row_s;

    // Clamp each neighbour coordinate, then flatten to raster addresses.
    always_comb begin
        xl_s = (x == '0)    ? x : x - A_ONE;
        xr_s = (x == X_MAX) ? x : x + A_ONE;
        yu_s = (y == '0)    ? y : y - A_ONE;
        yd_s = (y == Y_MAX) ? y : y + A_ONE;
        row_s      = y * A_W;
        left_addr  = row_s + xl_s;
        right_addr = row_s + xr_s;
        up_addr    = yu_s * A_W + x;
        down_addr  = yd_s * A_W + x;
    end

endmodule

// File: rtl/gradient_builder.sv
// Raster pass over a pixel BRAM producing halved central-difference x/y
// gradients, one pixel every 7 cycles, written to two gradient BRAMs.
module gradient_builder
    import sift_pkg::*;
#(
    parameter  int WIDTH     = 3,
    parameter  int HEIGHT    = 3,
    parameter  int BIT_DEPTH = 8,
    localparam int ADDR_W    = addr_width(WIDTH * HEIGHT)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    output logic [ADDR_W-1:0]    img_read_addr,
    output logic                 img_read_valid,
    input  logic [BIT_DEPTH-1:0] img_pixel_in,
    output logic [ADDR_W-1:0]    grad_write_addr,
    output logic                 grad_write_valid,
    output logic [BIT_DEPTH-1:0] x_grad_out,
    output logic [BIT_DEPTH-1:0] y_grad_out,
    output logic                 busy_out,
    output logic                 done_out
);

    localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] X_MAX  = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] N_LAST = ADDR_W'(WIDTH * HEIGHT - 1);

    grad_state_t        state_r;
    logic [1:0]         sub_r;
    logic [ADDR_W-1:0]  x_r;
    logic [ADDR_W-1:0]  y_r;
    logic [ADDR_W-1:0]  pix_r;
    logic [ADDR_W-1:0]  nx_s;
    logic [ADDR_W-1:0]  ny_s;
    logic [ADDR_W-1:0]  left_s;
    logic [ADDR_W-1:0]  right_s;
    logic [ADDR_W-1:0]  up_s;
    logic [ADDR_W-1:0]  down_s;
    read_tag_t          next_tag_s;
    logic [ADDR_W-1:0]  issue_addr_s;
    logic               issue_v_r;
    read_tag_t          issue_tag_r;
    logic [BRAM_RD_LAT-1:0] pipe_v_r;
    read_tag_t          pipe_tag_r [BRAM_RD_LAT];
    logic               cap_v_s;
    read_tag_t          cap_tag_s;
    logic [BIT_DEPTH-1:0] l_r;
    logic [BIT_DEPTH-1:0] r_r;
    logic [BIT_DEPTH-1:0] u_r;
    logic [BIT_DEPTH-1:0] d_r;
    logic [BIT_DEPTH-1:0] d_cur_s;
    logic [BIT_DEPTH-1:0] x_grad_s;
    logic [BIT_DEPTH-1:0] y_grad_s;

    // (b - a) >>> 1 on a one-bit-wider signed value; the result always fits BIT_DEPTH.
    function automatic logic [BIT_DEPTH-1:0] half_diff(input logic [BIT_DEPTH-1:0] a,
                                                       input logic [BIT_DEPTH-1:0] b);
        logic signed [BIT_DEPTH:0] diff;
        diff = $signed({1'b0, b}) - $signed({1'b0, a});
        diff = diff >>> 1;
        return diff[BIT_DEPTH-1:0];
    endfunction

    // Coordinates of the pixel whose reads are issued at the coming edge.
    always_comb begin
        nx_s = x_r;
        ny_s = y_r;
        case (state_r)
            IDLE: begin
                nx_s = '0;
                ny_s = '0;
            end
            WRITE: begin
                if (x_r == X_MAX) begin
                    nx_s = '0;
                    ny_s = y_r + A_ONE;
                end else begin
                    nx_s = x_r + A_ONE;
                    ny_s = y_r;
                end
            end
            default: begin
                nx_s = x_r;
                ny_s = y_r;
            end
        endcase
    end

    neighbor_addr #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_neighbor_addr (
        .x          (nx_s),
        .y          (ny_s),
        .left_addr  (left_s),
        .right_addr (right_s),
        .up_addr    (up_s),
        .down_addr  (down_s)
    );

    // Select which neighbour address the next issued read targets.
    always_comb begin
        if (state_r == READ) begin
            next_tag_s = read_tag_t'(sub_r + 2'd1);
        end else begin
            next_tag_s = TAG_L;
        end
        case (next_tag_s)
            TAG_L:   issue_addr_s = left_s;
            TAG_R:   issue_addr_s = right_s;
            TAG_U:   issue_addr_s = up_s;
            TAG_D:   issue_addr_s = down_s;
            default: issue_addr_s = left_s;
        endcase
    end

    // Capture side: the tag at the end of the latency pipe says which register the word fills.
    always_comb begin
        cap_v_s   = pipe_v_r[BRAM_RD_LAT-1];
        cap_tag_s = pipe_tag_r[BRAM_RD_LAT-1];
        if (cap_v_s && (cap_tag_s == TAG_D)) begin
            d_cur_s = img_pixel_in;
        end else begin
            d_cur_s = d_r;
        end
        x_grad_s = half_diff(l_r, r_r);
        y_grad_s = half_diff(u_r, d_cur_s);
    end

    // Main FSM with registered outputs; reads, writes and done are one-cycle strobes.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r          <= IDLE;
            sub_r            <= 2'd0;
            x_r              <= '0;
            y_r              <= '0;
            pix_r            <= '0;
            img_read_addr    <= '0;
            img_read_valid   <= 1'b0;
            issue_v_r        <= 1'b0;
            issue_tag_r      <= TAG_L;
            grad_write_addr  <= '0;
            grad_write_valid <= 1'b0;
            x_grad_out       <= '0;
            y_grad_out       <= '0;
            busy_out         <= 1'b0;
            done_out         <= 1'b0;
        end else begin
            img_read_valid   <= 1'b0;
            issue_v_r        <= 1'b0;
            grad_write_valid <= 1'b0;
            done_out         <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_in) begin
                        state_r        <= READ;
                        sub_r          <= 2'd0;
                        x_r            <= nx_s;
                        y_r            <= ny_s;
                        pix_r          <= '0;
                        busy_out       <= 1'b1;
                        img_read_valid <= 1'b1;
                        img_read_addr  <= issue_addr_s;
                        issue_v_r      <= 1'b1;
                        issue_tag_r    <= next_tag_s;
                    end
                end
                READ: begin
                    if (sub_r == 2'd3) begin
                        state_r <= WAIT;
                        sub_r   <= 2'd0;
                    end else begin
                        sub_r          <= sub_r + 2'd1;
                        img_read_valid <= 1'b1;
                        img_read_addr  <= issue_addr_s;
                        issue_v_r      <= 1'b1;
                        issue_tag_r    <= next_tag_s;
                    end
                end
                WAIT: begin
                    if (sub_r == 2'd1) begin
                        state_r          <= WRITE;
                        sub_r            <= 2'd0;
                        grad_write_valid <= 1'b1;
                        grad_write_addr  <= pix_r;
                        x_grad_out       <= x_grad_s;
                        y_grad_out       <= y_grad_s;
                    end else begin
                        sub_r <= sub_r + 2'd1;
                    end
                end
                WRITE: begin
                    if (pix_r == N_LAST) begin
                        state_r  <= DONE;
                        busy_out <= 1'b0;
                        done_out <= 1'b1;
                    end else begin
                        state_r        <= READ;
                        sub_r          <= 2'd0;
                        x_r            <= nx_s;
                        y_r            <= ny_s;
                        pix_r          <= pix_r + A_ONE;
                        img_read_valid <= 1'b1;
                        img_read_addr  <= issue_addr_s;
                        issue_v_r      <= 1'b1;
                        issue_tag_r    <= next_tag_s;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Delay each read's tag by the BRAM latency so it lines up with its data word.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < BRAM_RD_LAT; i++) begin
                pipe_v_r[i]   <= 1'b0;
                pipe_tag_r[i] <= TAG_L;
            end
        end else begin
            pipe_v_r[0]   <= issue_v_r;
            pipe_tag_r[0] <= issue_tag_r;
            for (int i = 1; i < BRAM_RD_LAT; i++) begin
                pipe_v_r[i]   <= pipe_v_r[i-1];
                pipe_tag_r[i] <= pipe_tag_r[i-1];
            end
        end
    end

    // Neighbour capture registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            l_r <= '0;
            r_r <= '0;
            u_r <= '0;
            d_r <= '0;
        end else if (cap_v_s) begin
            case (cap_tag_s)
                TAG_L:   l_r <= img_pixel_in;
                TAG_R:   r_r <= img_pixel_in;
                TAG_U:   u_r <= img_pixel_in;
                TAG_D:   d_r <= img_pixel_in;
                default: l_r <= l_r;
            endcase
        end
    end

endmodule

// File: tb/tb_gradient_builder.sv
// Directed bench for gradient_builder on a 3x3 image with a 2-cycle BRAM model.
module tb_gradient_builder;
    import sift_pkg::*;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       start_in;
    logic [3:0] img_read_addr;
    logic       img_read_valid;
    logic [7:0] img_pixel_in;
    logic [3:0] grad_write_addr;
    logic       grad_write_valid;
    logic [7:0] x_grad_out;
    logic [7:0] y_grad_out;
    logic       busy_out;
    logic       done_out;

    gradient_builder #(.WIDTH(3), .HEIGHT(3), .BIT_DEPTH(8)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .start_in         (start_in),
        .img_read_addr    (img_read_addr),
        .img_read_valid   (img_read_valid),
        .img_pixel_in     (img_pixel_in),
        .grad_write_addr  (grad_write_addr),
        .grad_write_valid (grad_write_valid),
        .x_grad_out       (x_grad_out),
        .y_grad_out       (y_grad_out),
        .busy_out         (busy_out),
        .done_out         (done_out)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int start_cyc;

    logic [7:0] mem [16];
    logic [7:0] rd1;

    // Hand-computed nominal expectations for rows [10,20,30],[40,50,60],[70,80,90].
    int exp_x  [9] = '{5, 10, 5, 5, 10, 5, 5, 10, 5};
    int exp_y  [9] = '{15, 15, 15, 30, 30, 30, 15, 15, 15};
    int exp_rd [36] = '{0,1,0,3, 0,2,1,4, 1,2,2,5, 3,4,0,6, 3,5,1,7,
                        4,5,2,8, 6,7,3,6, 6,8,4,7, 7,8,5,8};

    int wr_cnt, done_cnt, done_cyc, rd_first;
    logic done_busy;
    logic [7:0] wr_x [16];
    logic [7:0] wr_y [16];
    int wr_cyc [16];
    int rd_q [$];

    always @(posedge clk_in) cyc <= cyc + 1;

    // Two-cycle-latency pixel BRAM.
    always @(posedge clk_in) begin
        rd1          <= mem[img_read_addr];
        img_pixel_in <= rd1;
    end

    always @(negedge clk_in) begin
        if (grad_write_valid) begin
            wr_x[grad_write_addr]   = x_grad_out;
            wr_y[grad_write_addr]   = y_grad_out;
            wr_cyc[grad_write_addr] = cyc;
            wr_cnt++;
        end
        if (img_read_valid) begin
            if (rd_q.size() == 0) rd_first = cyc;
            rd_q.push_back(int'(img_read_addr));
        end
        if (done_out) begin
            done_cyc  = cyc;
            done_busy = busy_out;
            done_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {4'h0, img_read_addr, img_read_valid, grad_write_addr, grad_write_valid,
                x_grad_out, y_grad_out, busy_out, done_out};
    endfunction

    task automatic clear_rec();
        wr_cnt = 0; done_cnt = 0; done_cyc = -1; rd_first = -1; done_busy = 1'bx;
        rd_q.delete();
        for (int i = 0; i < 16; i++) begin
            wr_x[i] = 8'hxx; wr_y[i] = 8'hxx; wr_cyc[i] = -1;
        end
    endtask

    task automatic begin_pass();
        clear_rec();
        @(negedge clk_in);
        start_cyc = cyc;
        start_in  = 1'b1;
        @(negedge clk_in);
        start_in  = 1'b0;
    endtask

    task automatic run_pass(input bit repulse);
        begin_pass();
        for (int i = 0; i < 200 && done_cnt == 0; i++) begin
            @(negedge clk_in);
            start_in = (repulse && (cyc - start_cyc == 20)) ? 1'b1 : 1'b0;
        end
        start_in = 1'b0;
        check_eq("pass_done_seen", 32'(done_cnt), 32'd1);
        repeat (2) @(negedge clk_in);
    endtask

    task automatic check_nominal(input string pfx);
        int bad_t;
        bad_t = 0;
        check_eq({pfx, "_wr_cnt"}, 32'(wr_cnt), 32'd9);
        for (int a = 0; a < 9; a++) begin
            check_eq($sformatf("%s_x%0d", pfx, a), 32'(wr_x[a]), 32'(exp_x[a]));
            check_eq($sformatf("%s_y%0d", pfx, a), 32'(wr_y[a]), 32'(exp_y[a]));
            if (wr_cyc[a] - start_cyc != 7 * (a + 1)) bad_t++;
        end
        check_eq({pfx, "_wr_timing_bad"}, 32'(bad_t), 32'd0);
        check_eq({pfx, "_done_cyc"}, 32'(done_cyc - start_cyc), 32'd64);
        check_eq({pfx, "_busy_at_done"}, 32'(done_busy), 32'd0);
        check_eq({pfx, "_first_rd_cyc"}, 32'(rd_first - start_cyc), 32'd1);
        check_eq({pfx, "_rd_cnt"}, 32'(rd_q.size()), 32'd36);
        for (int i = 0; i < 36 && i < rd_q.size(); i++) begin
            check_eq($sformatf("%s_rd%0d", pfx, i), 32'(rd_q[i]), 32'(exp_rd[i]));
        end
    endtask

    task automatic load_nominal();
        for (int i = 0; i < 16; i++) mem[i] = (i < 9) ? 8'(10 * (i + 1)) : 8'h00;
    endtask

    initial begin
        int nz;
        rst_in   = 1'b1;
        start_in = 1'b0;
        load_nominal();
        clear_rec();
        repeat (3) @(negedge clk_in);
        check_eq("reset_outs", all_outs(), 32'h0);
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);

        run_pass(1'b0);
        check_nominal("nom");

        // Saturation: rows [0,128,255],[255,128,0],[255,128,0]
        mem[0] = 8'd0;   mem[1] = 8'd128; mem[2] = 8'd255;
        mem[3] = 8'd255; mem[4] = 8'd128; mem[5] = 8'd0;
        mem[6] = 8'd255; mem[7] = 8'd128; mem[8] = 8'd0;
        run_pass(1'b0);
        check_eq("sat_x_pos", 32'(wr_x[1]), 32'h7F);
        check_eq("sat_x_neg", 32'(wr_x[4]), 32'h80);
        check_eq("sat_y_pos", 32'(wr_y[3]), 32'h7F);
        check_eq("sat_y_neg", 32'(wr_y[5]), 32'h80);
        check_eq("sat_x_clamp", 32'(wr_x[0]), 32'h40);

        for (int i = 0; i < 9; i++) mem[i] = 8'd77;
        run_pass(1'b0);
        nz = 0;
        for (int a = 0; a < 9; a++) if (wr_x[a] !== 8'd0 || wr_y[a] !== 8'd0) nz++;
        check_eq("flat_wr_cnt", 32'(wr_cnt), 32'd9);
        check_eq("flat_nonzero", 32'(nz), 32'd0);

        load_nominal();
        run_pass(1'b1);
        check_nominal("repulse");

        // Reset asserted during cycle 30 of a pass.
        begin_pass();
        for (int i = 0; i < 100 && (cyc - start_cyc) < 30; i++) @(negedge clk_in);
        check_eq("midrst_at_30", 32'(cyc - start_cyc), 32'd30);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        check_eq("midrst_outs", all_outs(), 32'h0);
        check_eq("midrst_state", 32'(dut.state_r), 32'(IDLE));
        check_eq("midrst_wr_before", 32'(wr_cnt), 32'd4);
        repeat (10) @(negedge clk_in);
        check_eq("midrst_wr_after", 32'(wr_cnt), 32'd4);
        check_eq("midrst_idle_busy", 32'(busy_out), 32'd0);
        run_pass(1'b0);
        check_nominal("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gradient_builder.md
# gradient_builder

Writer-side companion to `gradient_orientation`. It reads one scale-space image from a single-port pixel BRAM and computes signed central-difference x and y gradients per pixel. It writes them at matching addresses into the x-gradient and y-gradient BRAMs that `gradient_orientation` later reads. It runs one full raster pass per `start_in` pulse.

## Interface
Parameters:
- `WIDTH`, 3: image width in pixels.
- `HEIGHT`, 3: image height in pixels.
- `BIT_DEPTH`, 8: pixel width (unsigned in) and gradient width (two's-complement out).
- Derived `ADDR_W` = `$clog2(WIDTH*HEIGHT)`; address = y*WIDTH + x.

Ports:
- `clk_in`  in  1  system clock; the only clock.
- `rst_in`  in  1  synchronous, active-high reset.
- `start_in`  in  1  one-cycle pulse that begins a pass; honoured only in IDLE.
- `img_read_addr`  out  ADDR_W  pixel BRAM read address.
- `img_read_valid`  out  1  high on cycles that issue a read.
- `img_pixel_in`  in  BIT_DEPTH  BRAM data, valid exactly 2 cycles after the address cycle.
- `grad_write_addr`  out  ADDR_W  shared write address for both gradient BRAMs.
- `grad_write_valid`  out  1  write enable for both gradient BRAMs.
- `x_grad_out`  out  BIT_DEPTH  signed x gradient.
- `y_grad_out`  out  BIT_DEPTH  signed y gradient.
- `busy_out`  out  1  high from the cycle after accepted start through the last write.
- `done_out`  out  1  one-cycle pulse after the last write.

## Operation
- States:
  - IDLE: waits for `start_in`.
  - READ: 4 sub-cycles issuing left, right, up, down reads.
  - WAIT: 2 cycles collecting the last two data words.
  - WRITE: 1 cycle.
  - DONE: 1 cycle, then back to IDLE.
- Pixel order is raster: x fastest, then y, from (0,0) to (WIDTH-1,HEIGHT-1).
- Neighbour addresses clamp at borders by replicating the centre coordinate on that axis:
  - x=0 uses the centre as left; x=WIDTH-1 uses the centre as right.
  - The same rule applies for y (up/down).
  - No extra reads are issued.
- Arithmetic:
  - Extend pixels to BIT_DEPTH+1 bits signed.
  - diff = R−L (x) or D−U (y).
  - Output = diff >>> 1 (arithmetic shift), truncated to BIT_DEPTH bits. This always fits: range −2^(B−1)..2^(B−1)−1.
- Incoming `img_pixel_in` words are captured into L/R/U/D registers tagged by read order, not by re-deriving the address.
- `start_in` while busy is ignored.
- Reset at any time:
  - Returns to IDLE.
  - Drives all outputs to 0 on the next edge.
  - Abandons the partial pass; gradient BRAM contents are left undefined.

## Timing
- Cycle 0 is `start_in` high in IDLE. `busy_out` rises at cycle 1.
- For pixel k (0-based):
  - Reads are issued at cycles 1+7k … 4+7k in order L, R, U, D.
  - Data is sampled at cycles 3+7k … 6+7k.
  - Write (`grad_write_valid`=1, addr=k, gradients) occurs in cycle 7+7k.
  - Throughput is 7 cycles/pixel, with no overlap between pixels.
- Last write is at cycle 7N (N = WIDTH*HEIGHT).
- At cycle 7N+1: `done_out`=1 and `busy_out`=0. IDLE follows at 7N+2, when a new start may be accepted.
- `img_read_valid` is high only during READ cycles. `grad_write_valid` is high only during WRITE.
- Address and data outputs are don't-care when their valid is low, but are held at 0 after reset.
- All outputs are registered. Reset values are 0 for every output.

## Structure
- Shared package `sift_pkg`:
  - `grad_state_t` enum (IDLE, READ, WAIT, WRITE, DONE).
  - BRAM read-latency constant `BRAM_RD_LAT` = 2.
  - Address-width helper.
- One combinational sub-module, `neighbor_addr`: takes (x, y, WIDTH, HEIGHT) and produces the four clamped neighbour addresses.
- The FSM, counters, capture registers and subtractors live in the top module.

## Test plan
- Nominal 3×3 pass:
  - Image rows [10,20,30],[40,50,60],[70,80,90].
  - Expect addr 4 → x=10, y=30.
  - Expect addr 0 → x=5, y=15.
  - Expect addr 8 → x=5, y=15.
  - 9 writes at cycles 7,14,…,63; `done_out` at 64.
- Saturation extremes:
  - Left=0, right=255 → x=127.
  - Left=255, right=0 → x=−128 (0x80).
  - The same check on the y axis.
- Flat image (all 77) → every write x=0, y=0.
- Address sequence: verify the clamped L/R/U/D read addresses for all 9 pixels, e.g. pixel 0 reads 0,1,0,3.
- `start_in` re-pulsed at cycle 20 mid-pass → ignored; writes and done timing unchanged.
- `rst_in` asserted at cycle 30 for 1 cycle:
  - All outputs are 0 at cycle 31 and the FSM is in IDLE.
  - A fresh start then produces the full nominal result.
